// File: rtl/out_bus_arbiter.sv
// Round-robin arbiter sharing the dedicated output bus among N_REQ requesters.
// A requester keeps the bus for a burst of beats. The tenure ends on last,
// when the request drops, when ena falls, or when the MAX_HOLD limit is hit.
// Every tenure is followed by one turnaround cycle.
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   ena         - global enable; low ends the current tenure and blocks new grants
//   req, last   - per-requester request level and final-beat marker
//   data        - packed requester data, requester i on [i*DW +: DW]
//   gnt         - registered one-hot grant (or zero)
//   bus_out     - registered beat data; bus_valid flags a transferred beat
//   preempt     - one-cycle pulse when a tenure was cut by the hold limit
module out_bus_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      last,
  input  logic [N_REQ*DW-1:0]   data,
  output logic [N_REQ-1:0]      gnt,
  output logic [DW-1:0]         bus_out,
  output logic                  bus_valid,
  output logic                  preempt
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [PW-1:0] PTR_MAX   = PW'(N_REQ - 1);
  localparam logic [PW:0]   N_WIDE    = (PW + 1)'(N_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [PW-1:0]    g_idx, g_idx_n;
  logic [HW-1:0]    hold_cnt, hold_cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [DW-1:0]    bus_n;
  logic             valid_n, preempt_n;

  // Lane of the currently granted requester
  logic          req_g, last_g;
  logic [DW-1:0] data_g;
  always_comb begin
    req_g  = 1'b0;
    last_g = 1'b0;
    data_g = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (g_idx == PW'(i)) begin
        req_g  = req[i];
        last_g = last[i];
        data_g = data[i*DW +: DW];
      end
    end
  end

  // Round-robin pick: first requester at or after ptr, modulo N_REQ.
  // ptr + k is at most 2*N_REQ-2, so one conditional subtract is enough.
  logic          win_vld;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (PW + 1)'(k);
      if (cand >= N_WIDE) cand = cand - N_WIDE;
      if (!win_vld && req[PW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = PW'(cand);
      end
    end
  end

  logic [PW-1:0] ptr_after;
  assign ptr_after = (g_idx == PTR_MAX) ? '0 : g_idx + PW'(1);

  // Next state and next registered outputs
  logic tenure_end;
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    g_idx_n    = g_idx;
    hold_cnt_n = hold_cnt;
    gnt_n      = '0;
    bus_n      = '0;
    valid_n    = 1'b0;
    preempt_n  = 1'b0;
    tenure_end = 1'b0;
    case (state)
      IDLE: begin
        if (ena && win_vld) begin
          state_n    = GRANT;
          g_idx_n    = win_idx;
          gnt_n      = N_REQ'(1) << win_idx;
          hold_cnt_n = '0;
        end
      end
      GRANT: begin
        // Cause priority: ena low, then dropped request, then last, then hold limit
        if (!ena || !req_g) begin
          tenure_end = 1'b1;
        end else begin
          bus_n   = data_g;
          valid_n = 1'b1;
          if (last_g) begin
            tenure_end = 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            tenure_end = 1'b1;
            preempt_n  = 1'b1;
          end
        end
        if (tenure_end) begin
          state_n = GAP;
          ptr_n   = ptr_after;
        end else begin
          gnt_n      = gnt;
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      g_idx     <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      g_idx     <= g_idx_n;
      hold_cnt  <= hold_cnt_n;
      gnt       <= gnt_n;
      bus_out   <= bus_n;
      bus_valid <= valid_n;
      preempt   <= preempt_n;
    end
  end

endmodule

// File: tb/tb_out_bus_arbiter.sv
// Self-checking bench for out_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// tenure-level reference model.
module tb_out_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  last = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]  gnt;
  logic [DW-1:0] bus_out;
  logic          bus_valid;
  logic          preempt;

  always #5 clk = ~clk;

  out_bus_arbiter #(.N_REQ(N), .DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .last(last), .data(data),
    .gnt(gnt), .bus_out(bus_out), .bus_valid(bus_valid), .preempt(preempt)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: who owns the bus, how long they have held it, where the
  // next search starts, and whether a turnaround cycle is pending.
  int owner = -1;
  int held  = 0;
  int rr    = 0;
  int gap   = 0;
  logic [N-1:0]  e_gnt;
  logic [DW-1:0] e_bus;
  logic          e_valid, e_pre;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    owner = -1; held = 0; rr = 0; gap = 0;
    e_gnt = '0; e_bus = '0; e_valid = 1'b0; e_pre = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit done;
    done = 0;
    e_gnt = '0; e_bus = '0; e_valid = 1'b0; e_pre = 1'b0;
    if (owner >= 0) begin
      held++;
      if (!ena || !req[owner]) done = 1;
      else begin
        e_valid = 1'b1;
        e_bus   = data[owner*DW +: DW];
        if (last[owner]) done = 1;
        else if (held == MH) begin done = 1; e_pre = 1'b1; end
      end
      if (done) begin
        rr = (owner + 1) % N;
        owner = -1;
        gap = 1;
      end else e_gnt[owner] = 1'b1;
    end else if (gap != 0) begin
      gap = 0;
    end else if (ena && req != 0) begin
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && req[(rr + k) % N]) owner = (rr + k) % N;
      end
      held = 0;
      e_gnt[owner] = 1'b1;
    end
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("bus_out", 32'(bus_out), 32'(e_bus));
    chk("bus_valid", 32'(bus_valid), 32'(e_valid));
    chk("preempt", 32'(preempt), 32'(e_pre));
  endtask

  task automatic settle();
    req = '0; last = '0;
    repeat (3) tick();
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] v);
    data[idx*DW +: DW] = v;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_bus_out", 32'(bus_out), 32'h0);
    chk("rst_bus_valid", 32'(bus_valid), 32'h0);
    chk("rst_preempt", 32'(preempt), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int order[$];
    logic [N-1:0] prev;
    int tc;
    int beats;

    model_reset();
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_valid", 32'(bus_valid), 32'h0);
    chk("reset_bus", 32'(bus_out), 32'h0);
    chk("reset_preempt", 32'(preempt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;
    tick();

    // All requesting, each ends on its 2nd beat: rotation 0,1,2,3,0
    req = '1; prev = '0; tc = 0;
    for (int c = 0; c < 24; c++) begin
      if (gnt != 0) tc++; else tc = 0;
      last = (tc == 2) ? gnt : '0;
      data = N*DW'($urandom);
      tick();
      if (gnt != 0 && prev == 0) order.push_back($clog2(gnt));
      prev = gnt;
    end
    for (int k = 0; k < 5; k++)
      chk("rr_order", (order.size() > k) ? 32'(order[k]) : 32'hdead, 32'(k % N));
    settle();

    // Single requester 2, three beats, last on the third
    req = 4'b0100;
    tick();                         chk("s1_gnt_t1", 32'(gnt), 32'h4);
    set_data(2, 8'h11); tick();     chk("s1_gnt_t2", 32'(gnt), 32'h4); chk("s1_bus_11", 32'(bus_out), 32'h11);
    set_data(2, 8'h22); tick();     chk("s1_bus_22", 32'(bus_out), 32'h22);
    set_data(2, 8'h33); last = 4'b0100; tick();
    chk("s1_gnt_t4", 32'(gnt), 32'h0); chk("s1_bus_33", 32'(bus_out), 32'h33);
    chk("s1_valid_t4", 32'(bus_valid), 32'h1); chk("s1_preempt", 32'(preempt), 32'h0);
    last = '0; tick();              chk("s1_gnt_t5", 32'(gnt), 32'h0);
    tick();                         chk("s1_regrant_t6", 32'(gnt), 32'h4);
    settle();

    // Requester 1 holds without last: preempted after MAX_HOLD cycles
    req = 4'b0110;
    tick();                         chk("s3_gnt_first", 32'(gnt), 32'h2);
    beats = 0;
    for (int k = 1; k < MH; k++) begin
      data = N*DW'($urandom);
      tick();
      if (bus_valid) beats++;
    end
    chk("s3_gnt_last", 32'(gnt), 32'h2);
    tick();
    if (bus_valid) beats++;
    chk("s3_drop", 32'(gnt), 32'h0); chk("s3_preempt", 32'(preempt), 32'h1);
    chk("s3_beats", 32'(beats), 32'(MH));
    tick();                         chk("s3_preempt_pulse", 32'(preempt), 32'h0);
    tick();                         chk("s3_next_req2", 32'(gnt), 32'h4);
    settle();

    // ena low during requester 0's 3rd grant cycle
    req = 4'b0001;
    repeat (3) tick();
    chk("s4_gnt_g3", 32'(gnt), 32'h1);
    ena = 1'b0; tick();
    chk("s4_gnt_off", 32'(gnt), 32'h0); chk("s4_no_beat", 32'(bus_valid), 32'h0);
    repeat (4) begin
      tick();
      chk("s4_blocked", 32'(gnt), 32'h0); chk("s4_preempt", 32'(preempt), 32'h0);
    end
    ena = 1'b1;
    repeat (3) tick();
    settle();

    // Asynchronous reset mid-tenure, then ptr back at 0
    req = '1;
    repeat (3) tick();
    async_reset();
    req = 4'b1001;
    tick();                         chk("s5_after_rst", 32'(gnt), 32'h1);
    settle();

    // Requester 3 drops req with last=1 in its 2nd grant cycle
    req = 4'b1000;
    tick(); tick();                 chk("s6_gnt_g2", 32'(gnt), 32'h8);
    req = 4'b0000; last = 4'b1000; tick();
    chk("s6_gnt_off", 32'(gnt), 32'h0); chk("s6_no_beat", 32'(bus_valid), 32'h0);
    chk("s6_preempt", 32'(preempt), 32'h0);
    req = 4'b1001; last = '0;
    tick(); tick();                 chk("s6_wrap_to_0", 32'(gnt), 32'h1);
    settle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit long_mode;
      long_mode = ((c / 250) % 2) == 1;
      req  = N'($urandom | $urandom);
      last = long_mode ? N'($urandom & $urandom & $urandom & $urandom & $urandom)
                       : N'($urandom & $urandom);
      ena  = ($urandom_range(0, 19) != 0);
      data = {$urandom};
      if ($urandom_range(0, 699) == 0) async_reset();
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/out_bus_arbiter.md
Name: out_bus_arbiter

Overview:
- Round-robin arbiter that shares the 8-bit dedicated output bus (uo_out) between N internal requesters inside the tt_um top level.
- Each requester holds the bus for a burst of beats, then releases it; a hold-time limit prevents starvation.
- Sits between the requester blocks and the uo_out assignment; the top level drives uo_out from bus_out.
- All outputs are registered.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width per requester and of bus_out.
- MAX_HOLD, 16, maximum number of GRANT cycles per tenure (>=2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; low forces release and blocks new grants.
- req  input  N_REQ  per-requester bus request, level.
- last  input  N_REQ  per-requester final-beat marker; qualified by req and gnt.
- data  input  N_REQ*DW  packed requester data; requester i uses bits [i*DW +: DW].
- gnt  output  N_REQ  one-hot grant, or all zero.
- bus_out  output  DW  registered output bus to uo_out.
- bus_valid  output  1  bus_out carries a transferred beat this cycle.
- preempt  output  1  one-cycle pulse when a tenure is ended by the MAX_HOLD limit.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, bus_out=0, bus_valid=0, preempt=0.
  - state=IDLE, ptr=0, hold_cnt=0.
  - Reset asserted mid-tenure aborts that tenure immediately. The beat in flight is lost.
- States: IDLE, GRANT, GAP.
- IDLE:
  - gnt=0, bus_valid=0, bus_out=0.
  - If ena=1 and req!=0: the winner is the first index i with req[i]=1, scanning ptr, ptr+1, ... with wrap modulo N_REQ.
  - Next cycle: gnt=onehot(i), hold_cnt=0, state=GRANT.
  - Latency: req sampled at cycle t gives gnt at t+1.
- GRANT (granted index g):
  - A cycle with req[g]=1 is a beat. It is registered: bus_out=data[g] and bus_valid=1 at the next cycle.
  - A GRANT cycle with req[g]=0 transfers no beat. The next cycle has bus_valid=0 and bus_out=0.
  - hold_cnt increments every GRANT cycle.
  - The tenure ends in the first GRANT cycle in which any of these holds:
    (a) req[g]=0;
    (b) req[g]=1 and last[g]=1, with the beat still transferred;
    (c) hold_cnt==MAX_HOLD-1, with the beat still transferred if req[g]=1;
    (d) ena=0, with no beat transferred.
  - On the ending cycle: next gnt=0, next ptr=(g+1) mod N_REQ, next state=GAP.
  - preempt=1 in the next cycle only if (c) is the sole cause, i.e. (a), (b) and (d) are all false.
  - Priority when several causes coincide: (d) > (a) > (b) > (c).
- GAP:
  - One mandatory turnaround cycle: gnt=0, then state=IDLE.
  - bus_valid and bus_out reflect the final beat of the tenure that just ended, if that beat was transferred.
  - The minimum spacing from one tenure's end to the next gnt is 2 cycles.
- req/last of non-granted requesters are ignored.
- data is sampled only for the granted requester.
- gnt is never asserted while ena=0.
- Round-robin fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,N_REQ-1,0,...
- ptr updates only at tenure end. ptr is unchanged after reset until the first tenure completes.
- hold_cnt width: clog2(MAX_HOLD). It never wraps, because the tenure ends at MAX_HOLD-1.

Test Plan:
- Single requester: req[2]=1 for 3 cycles with data 0x11, 0x22, 0x33 and last on the third.
  -> gnt=0b0100 at t+1..t+3.
  -> bus_valid at t+2..t+4 with 0x11, 0x22, 0x33.
  -> gnt=0 at t+4. Next grant no earlier than t+6.
  -> preempt stays 0.
- All four requesting continuously, each asserting last on its 2nd beat.
  -> grant order 0,1,2,3,0.
  -> each tenure is 2 gnt cycles, separated by 2-cycle gaps.
- Requester 1 holds req without last, MAX_HOLD=16.
  -> gnt[1] high for exactly 16 cycles and 16 beats are transferred.
  -> preempt pulses for 1 cycle when gnt drops.
  -> next grant goes to requester 2 if it is requesting.
- ena driven low during the 3rd GRANT cycle of requester 0.
  -> that cycle transfers no beat; gnt=0 next cycle.
  -> no new grant while ena=0; preempt stays 0.
- rst_n pulsed low mid-tenure (asynchronous, between clock edges).
  -> gnt, bus_out, bus_valid and preempt go to 0 immediately.
  -> after release, requests 0 and 3 arriving together select 0 (ptr=0).
- Requester 3 drops req in its 2nd GRANT cycle with last=1.
  -> cause (a) wins: no beat is transferred in that cycle; preempt=0.
  -> ptr wraps so the next winner is 0 when 0 and 3 both request.
